ps2_host_rx: RTL and testbench
==============================

Name: ps2_host_rx

Overview:
- Host-side PS/2 receiver for cores that consume the emulated keyboard/mouse lines (ps2_kbd_clk/ps2_kbd_data, ps2_mouse_clk/ps2_mouse_data).
- Synchronises and filters the PS/2 clock, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and folds E0/F0 prefix bytes into flags.
- Queues decoded scancodes in a small first-word-fall-through FIFO read by the core.

Parameters:
FILTER, 4, consecutive equal samples of the synchronised clock required to change the filtered clock level (2..8)
TIMEOUT, 50000, clk_sys cycles without a falling edge mid-frame before the frame is aborted
FIFO_BITS, 2, log2 of FIFO depth

Ports:
clk_sys  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  PS/2 clock line, asynchronous to clk_sys, idle high
ps2_data  input  1  PS/2 data line, asynchronous, idle high
rd  input  1  pop FIFO head; ignored when empty
dout  output  8  scancode at FIFO head; 0 when empty
ext  output  1  head entry was preceded by E0; 0 when empty
rel  output  1  head entry was preceded by F0; 0 when empty
empty  output  1  FIFO empty
overflow  output  1  one-cycle pulse: decoded code dropped because FIFO full
parity_err  output  1  one-cycle pulse: frame discarded, bad parity
frame_err  output  1  one-cycle pulse: frame discarded, bad stop bit or timeout

Behaviour:
- Reset values: empty=1; dout, ext and rel read 0; all pulses 0; FSM in IDLE; prefix flags clear; pointers 0; synchronisers, filter and filtered clock all 1.
- Synchroniser: 2-FF chain on each line.
- Filter: shift register of the last FILTER synchronised clock samples.
  - Filtered clock goes 0 when all samples are 0 and 1 when all are 1; otherwise it holds.
  - A falling edge ("fall") is a 1->0 change of the filtered clock, registered. Synchronised data is sampled in the fall cycle.
- FSM IDLE:
  - fall with data=0 -> RECV, bit_cnt=0.
  - fall with data=1 -> stay in IDLE; no error.
- FSM RECV, on each fall:
  - bit_cnt 0..7: sr <= {d, sr[7:1]}.
  - bit_cnt 8: latch the parity bit.
  - bit_cnt 9: stop bit; return to IDLE and evaluate the frame.
  - Stop=0 -> frame_err; this takes precedence over a parity error.
  - Otherwise, XOR of the 8 data bits and the parity bit = 0 -> parity_err.
  - Otherwise the byte is valid.
  - Error pulses fire in the cycle after the stop-bit fall. Discarded frames do not touch the prefix flags.
- Timeout:
  - Counter clears on every fall and is held at 0 in IDLE.
  - In RECV, when the counter reaches TIMEOUT: go to IDLE, pulse frame_err the next cycle, discard partial data.
- Decode (cycle E+1, where E is the stop-bit fall cycle):
  - 0xE0 sets ext_pend; 0xF0 sets rel_pend; neither is pushed.
  - Any other byte, including E1, is pushed as {rel_pend, ext_pend, byte}; both pending flags then clear.
  - The pending flags clear even if the push is dropped.
- FIFO: depth 2^FIFO_BITS, entry width 10 bits, first-word-fall-through.
  - Write at the end of cycle E+1; empty=0 visible from E+2.
  - rd while !empty advances rptr; the new head is visible next cycle.
  - Write while full is dropped and pulses overflow (cycle E+2), unless rd pops in the same cycle; then the write is accepted and the count is unchanged.
  - Read and write in the same cycle when not full: both occur.
  - Pointers wrap modulo depth; one extra count bit distinguishes full from empty.
- Reset mid-frame: the partial frame and prefixes are lost; after release the receiver waits in IDLE for the next start bit.

Test Plan:
- Frame 0x1C, parity 0, stop 1, clock half-period 101 cycles -> empty falls at E+2; dout=0x1C, ext=0, rel=0; one rd -> empty=1, dout=0.
- Frames E0, F0, 74 -> exactly one entry: dout=0x74, ext=1, rel=1. Then frame 0x74 -> entry with ext=0, rel=0.
- Frame 0x55 with parity bit 0 -> single parity_err pulse at E+1, no entry. A following valid 0x1C is queued normally. A frame with stop=0 -> frame_err only.
- Start bit plus 5 data bits, then the line idles for TIMEOUT+10 cycles -> one frame_err pulse, FSM back in IDLE. A following 0x29 is decoded correctly.
- 2-cycle low glitch on ps2_clk while idle (FILTER=4) -> no fall, no state change. A 3-cycle glitch during RECV -> no extra bit shifted.
- FIFO_BITS=2: send 0x16,0x1E,0x26,0x25,0x2E without rd -> 4 entries kept, one overflow pulse, 0x2E absent, pops return entries in order. Then assert reset mid-frame -> empty=1; the next full frame is decoded cleanly.

Source files
------------

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises and filters the PS/2 clock, deserialises
// 11-bit frames, folds E0/F0 prefixes into flags and queues scancodes in a
// small first-word-fall-through FIFO.
module ps2_host_rx #(
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 50000,
    parameter int FIFO_BITS = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       ext,
    output logic       rel,
    output logic       empty,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic [1:0]        clk_sync_q, dat_sync_q;
    logic [FILTER-1:0] filt_q;
    logic              fclk_q, fclk_d, fall_q;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic              par_q, par_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              vld_q, vld_d, perr_q, perr_d, ferr_q, ferr_d;

    logic              ext_pend_q, rel_pend_q;
    logic              is_e0, is_f0, push, pop, full, wr, ovf_d, overflow_q;
    logic [FIFO_BITS:0] wptr_q, rptr_q, count;
    logic [9:0]        mem_q [DEPTH];
    logic [9:0]        head;
    logic              dbit;

    assign dbit = dat_sync_q[1];

    // Two-flop synchronisers, idle-high
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // Filtered clock only changes after FILTER identical samples; otherwise it holds
    always_comb begin
        fclk_d = fclk_q;
        if (filt_q == '0)
            fclk_d = 1'b0;
        else if (&filt_q)
            fclk_d = 1'b1;
    end

    // Sample history, filtered level and registered falling-edge strobe
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            filt_q <= '1;
            fclk_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            filt_q <= {filt_q[FILTER-2:0], clk_sync_q[1]};
            fclk_q <= fclk_d;
            fall_q <= fclk_q & ~fclk_d;
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            vld_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            vld_q     <= vld_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next state: shift data on each fall, judge the frame on the stop bit,
    // abort when the line stalls mid-frame. A fall beats a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_d     = par_q;
        tmo_d     = '0;
        vld_d     = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_q && !dbit) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                end
            end
            RECV: begin
                tmo_d = tmo_q + 1'b1;
                if (fall_q) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        sr_d = {dbit, sr_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = dbit;
                    end else begin
                        state_d = IDLE;
                        if (!dbit)
                            ferr_d = 1'b1;
                        else if (!(^{sr_q, par_q}))
                            perr_d = 1'b1;
                        else
                            vld_d = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                    tmo_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prefix decode and FIFO control
    always_comb begin
        is_e0 = vld_q && (sr_q == 8'hE0);
        is_f0 = vld_q && (sr_q == 8'hF0);
        push  = vld_q && !is_e0 && !is_f0;
        count = wptr_q - rptr_q;
        full  = (count == (FIFO_BITS+1)'(DEPTH));
        empty = (wptr_q == rptr_q);
        pop   = rd && !empty;
        wr    = push && (!full || pop);
        ovf_d = push && full && !pop;
        head  = mem_q[rptr_q[FIFO_BITS-1:0]];
        dout  = empty ? 8'h00 : head[7:0];
        ext   = empty ? 1'b0 : head[8];
        rel   = empty ? 1'b0 : head[9];
    end

    // Pending prefix flags; cleared by any pushed code, even a dropped one
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
        end else if (is_e0) begin
            ext_pend_q <= 1'b1;
        end else if (is_f0) begin
            rel_pend_q <= 1'b1;
        end else if (push) begin
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
        end
    end

    // FIFO pointers and overflow strobe
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            overflow_q <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset needed
    always_ff @(posedge clk_sys) begin
        if (wr) mem_q[wptr_q[FIFO_BITS-1:0]] <= {rel_pend_q, ext_pend_q, sr_q};
    end

    assign overflow   = overflow_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_host_rx.sv
// Self-checking bench for ps2_host_rx: a hand-written vector table, directed
// corner sequences and randomized frames against a queue-based reference model.
module tb_ps2_host_rx;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 1000;
    localparam int DEPTH   = 4;

    logic clk_sys = 0, reset = 1, ps2_clk = 1, ps2_data = 1, rd = 0;
    logic [7:0] dout;
    logic ext, rel, empty, overflow, parity_err, frame_err;

    ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd(rd), .dout(dout), .ext(ext), .rel(rel), .empty(empty),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err));

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // pulse / event monitor, sampled away from the active edge
    int perr_seen = 0, ferr_seen = 0, ovf_seen = 0;
    int perr_cyc = -1, nempty_cyc = -1;
    bit prev_empty = 1;
    always @(negedge clk_sys) begin
        if (parity_err) begin perr_seen++; perr_cyc = cyc; end
        if (frame_err)  ferr_seen++;
        if (overflow)   ovf_seen++;
        if (prev_empty && !empty) nempty_cyc = cyc;
        prev_empty = empty;
    end

    // reference model: queue of {rel,ext,code}, pending prefixes, expected pulse counts
    bit [9:0] mq[$];
    bit m_ext = 0, m_rel = 0;
    int e_perr = 0, e_ferr = 0, e_ovf = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc_wait(int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic [10:0] mk_frame(logic [7:0] d, bit bad_par, bit stop);
        logic p;
        p = (~^d) ^ bad_par;   // odd parity over data+parity
        return {stop, p, d, 1'b0};
    endfunction

    task automatic model_frame(logic [7:0] d, bit bad_par, bit stop);
        if (!stop) e_ferr++;
        else if (bad_par) e_perr++;
        else if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_rel = 1;
        else begin
            if (mq.size() < DEPTH) mq.push_back({m_rel, m_ext, d});
            else e_ovf++;
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    int stop_cyc = 0;
    // Device-style bit timing: data changes while clock is high, fall mid-bit.
    task automatic send_bits(logic [10:0] bits, int nbits, int half, int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                cyc_wait(half / 2);
                ps2_clk = 0;
                cyc_wait(3);
                ps2_clk = 1;
                cyc_wait(half - half / 2 - 3);
            end else begin
                cyc_wait(half);
            end
            ps2_clk = 0;
            if (i == 10) stop_cyc = cyc;
            cyc_wait(half);
            ps2_clk = 1;
        end
        ps2_data = 1;
    endtask

    task automatic send_frame(logic [7:0] d, bit bad_par, bit stop, int half, int glitch_bit);
        send_bits(mk_frame(d, bad_par, stop), 11, half, glitch_bit);
        model_frame(d, bad_par, stop);
    endtask

    task automatic check_head(string tag);
        if (mq.size() == 0) begin
            chk({tag, "_empty"}, empty, 1);
            chk({tag, "_head"}, {rel, ext, dout}, 0);
        end else begin
            chk({tag, "_empty"}, empty, 0);
            chk({tag, "_head"}, {rel, ext, dout}, mq[0]);
        end
    endtask

    task automatic check_all(string tag);
        cyc_wait(4);
        #1;
        chk({tag, "_perr"}, perr_seen, e_perr);
        chk({tag, "_ferr"}, ferr_seen, e_ferr);
        chk({tag, "_ovf"}, ovf_seen, e_ovf);
        check_head(tag);
    endtask

    task automatic do_pop();
        @(negedge clk_sys) rd = 1;
        @(negedge clk_sys) rd = 0;
        if (mq.size() != 0) void'(mq.pop_front());
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         stop;
        bit         pop;
        bit         x_empty;
        logic [7:0] x_dout;
        bit         x_ext;
        bit         x_rel;
        int         x_perr;
        int         x_ferr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0, f0, lerr;
        tbl[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0, 0, 0};
        tbl[1]  = '{8'hE0, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        tbl[2]  = '{8'hF0, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        tbl[3]  = '{8'h74, 0, 1, 1, 0, 8'h74, 1, 1, 0, 0};
        tbl[4]  = '{8'h74, 0, 1, 1, 0, 8'h74, 0, 0, 0, 0};
        tbl[5]  = '{8'h55, 1, 1, 0, 1, 8'h00, 0, 0, 1, 0};
        tbl[6]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0, 0, 0};
        tbl[7]  = '{8'h1C, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1};
        tbl[8]  = '{8'h1C, 1, 0, 0, 1, 8'h00, 0, 0, 0, 1};
        tbl[9]  = '{8'hF0, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0};
        tbl[10] = '{8'hE0, 1, 1, 0, 1, 8'h00, 0, 0, 1, 0};
        tbl[11] = '{8'h6B, 0, 1, 1, 0, 8'h6B, 0, 1, 0, 0};
        tbl[12] = '{8'hE1, 0, 1, 1, 0, 8'hE1, 0, 0, 0, 0};

        // reset state
        cyc_wait(5);
        chk("rst_empty", empty, 1);
        chk("rst_outs", {dout, ext, rel, overflow, parity_err, frame_err}, 0);
        reset = 0;
        cyc_wait(5);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_outs", {dout, ext, rel, overflow, parity_err, frame_err}, 0);

        // table-driven frames
        for (int i = 0; i < 13; i++) begin
            p0 = perr_seen;
            f0 = ferr_seen;
            send_frame(tbl[i].d, tbl[i].bad_par, tbl[i].stop, 25, -1);
            cyc_wait(4);
            #1;
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].x_empty);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].x_dout);
            chk($sformatf("tbl%0d_extrel", i), {ext, rel}, {tbl[i].x_ext, tbl[i].x_rel});
            chk($sformatf("tbl%0d_perr", i), perr_seen - p0, tbl[i].x_perr);
            chk($sformatf("tbl%0d_ferr", i), ferr_seen - f0, tbl[i].x_ferr);
            if (tbl[i].pop) begin
                do_pop();
                chk($sformatf("tbl%0d_popped", i), {empty, dout}, {1'b1, 8'h00});
            end
        end

        // error pulse at E+1, entry visible at E+2, slow 101-cycle half period
        send_frame(8'h55, 1, 1, 101, -1);
        check_all("lat_perr");
        lerr = perr_cyc - stop_cyc;
        chk("lat_err_range", (lerr >= FILTER + 1 && lerr <= FILTER + 6), 1);
        send_frame(8'h1C, 0, 1, 101, -1);
        check_all("lat_1c");
        chk("lat_empty_fall", nempty_cyc - stop_cyc, lerr + 1);
        do_pop();
        chk("lat_pop", {empty, dout}, {1'b1, 8'h00});

        // stalled frame: start + 5 data bits, then the line idles
        send_bits(mk_frame(8'h3A, 0, 1), 6, 25, -1);
        e_ferr++;
        cyc_wait(TIMEOUT + 10);
        check_all("timeout");
        send_frame(8'h29, 0, 1, 25, -1);
        check_all("after_tmo");
        do_pop();

        // 2-cycle clock glitch while idle with data low must not start a frame
        ps2_data = 0;
        ps2_clk  = 0;
        cyc_wait(2);
        ps2_clk = 1;
        cyc_wait(10);
        ps2_data = 1;
        cyc_wait(10);
        send_frame(8'h1C, 0, 1, 25, -1);
        check_all("glitch_idle");
        do_pop();
        // 3-cycle glitch inside a frame must not shift an extra bit
        send_frame(8'hA5, 0, 1, 25, 4);
        check_all("glitch_recv");
        do_pop();

        // overflow: five codes into a depth-4 FIFO
        send_frame(8'h16, 0, 1, 20, -1);
        send_frame(8'h1E, 0, 1, 20, -1);
        send_frame(8'h26, 0, 1, 20, -1);
        send_frame(8'h25, 0, 1, 20, -1);
        send_frame(8'h2E, 0, 1, 20, -1);
        check_all("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check_head($sformatf("ovf_pop%0d", i));
        end

        // reset mid-frame with a pending F0 prefix
        send_frame(8'hF0, 0, 1, 20, -1);
        send_bits(mk_frame(8'h33, 0, 1), 5, 20, -1);
        reset = 1;
        cyc_wait(3);
        mq.delete();
        m_ext = 0;
        m_rel = 0;
        chk("midrst_outs", {empty, dout, ext, rel}, {1'b1, 8'h00, 1'b0, 1'b0});
        reset = 0;
        cyc_wait(5);
        check_all("midrst");
        send_frame(8'h1C, 0, 1, 20, -1);
        check_all("midrst_next");
        do_pop();

        // randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            int r, np;
            bit bp, st;
            r  = $urandom_range(0, 15);
            d  = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 15) != 0);
            send_frame(d, bp, st, $urandom_range(12, 30), -1);
            check_all($sformatf("rnd%0d", n));
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                do_pop();
                check_head($sformatf("rnd%0d_pop%0d", n, k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
